// File: rtl/multi_channel_receiver_pkg.sv
// multi_channel_receiver_pkg: default PWM timing limits, failsafe values and
// the per-channel FSM state type shared by the receiver files.
package multi_channel_receiver_pkg;
    localparam int PWM_VALUE_BIT_WIDTH = 8;
    localparam int PWM_TIME_BIT_WIDTH = 12;
    localparam int MIN_PULSE_US_DEF = 1000;
    localparam int MAX_PULSE_US_DEF = 2000;
    localparam int MIN_VALID_US_DEF = 800;
    localparam int MAX_VALID_US_DEF = 2200;
    localparam int VALUE_SHIFT_DEF = 2;
    localparam int TIMEOUT_US_DEF = 60000;
    localparam logic [4*PWM_VALUE_BIT_WIDTH-1:0] FAILSAFE_DEF = {8'd125, 8'd125, 8'd125, 8'd0};

    typedef enum logic [1:0] {WAIT_RISE, MEASURE, WAIT_FALL} rx_state_e;
endpackage

// File: rtl/rx_channel.sv
// rx_channel: one PWM channel -- synchronizer, pulse-width FSM, width-to-value
// mapping and the signal-loss timeout with failsafe substitution.
module rx_channel
    import multi_channel_receiver_pkg::*;
#(
    parameter int TIME_WIDTH = PWM_TIME_BIT_WIDTH,
    parameter int VALUE_WIDTH = PWM_VALUE_BIT_WIDTH,
    parameter int MIN_PULSE_US = MIN_PULSE_US_DEF,
    parameter int MAX_PULSE_US = MAX_PULSE_US_DEF,
    parameter int MIN_VALID_US = MIN_VALID_US_DEF,
    parameter int MAX_VALID_US = MAX_VALID_US_DEF,
    parameter int VALUE_SHIFT = VALUE_SHIFT_DEF,
    parameter int TIMEOUT_US = TIMEOUT_US_DEF,
    parameter logic [VALUE_WIDTH-1:0] FAILSAFE_VALUE = '0
) (
    input  logic                   us_clk,
    input  logic                   reset,
    input  logic                   pwm,
    output logic [VALUE_WIDTH-1:0] value,
    output logic                   update_strobe,
    output logic                   signal_lost,
    output logic                   pulse_error
);
    localparam logic [TIME_WIDTH-1:0] MIN_P = TIME_WIDTH'(MIN_PULSE_US);
    localparam logic [TIME_WIDTH-1:0] MAX_P = TIME_WIDTH'(MAX_PULSE_US);
    localparam logic [TIME_WIDTH-1:0] MIN_V = TIME_WIDTH'(MIN_VALID_US);
    localparam logic [TIME_WIDTH-1:0] MAX_V = TIME_WIDTH'(MAX_VALID_US);
    localparam logic [TIME_WIDTH-1:0] VMAX = TIME_WIDTH'((1 << VALUE_WIDTH) - 1);
    localparam logic [15:0] TO = 16'(TIMEOUT_US);

    logic s1, s, s_d, armed, rise, accept;
    logic [1:0] fill;
    rx_state_e state;
    logic [TIME_WIDTH-1:0] width, clamped, offset;
    logic [VALUE_WIDTH-1:0] mapped;
    logic [15:0] tcnt, tnext;

    // armed only once a genuine low level has been seen after reset, so a pulse
    // already high at reset release is never measured
    assign rise = s & ~s_d & armed;
    assign accept = (state == MEASURE) && !s && width >= MIN_V && width <= MAX_V;
    assign clamped = width < MIN_P ? MIN_P : width > MAX_P ? MAX_P : width;
    assign offset = (clamped - MIN_P) >> VALUE_SHIFT;
    assign mapped = offset > VMAX ? {VALUE_WIDTH{1'b1}} : offset[VALUE_WIDTH-1:0];
    assign tnext = tcnt == TO ? TO : tcnt + 16'd1;

    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s <= 1'b0;
            s_d <= 1'b0;
            fill <= 2'b00;
            armed <= 1'b0;
            state <= WAIT_RISE;
            width <= '0;
            tcnt <= '0;
            value <= FAILSAFE_VALUE;
            signal_lost <= 1'b1;
            update_strobe <= 1'b0;
            pulse_error <= 1'b0;
        end else begin
            s1 <= pwm;
            s <= s1;
            s_d <= s;
            fill <= {fill[0], 1'b1};
            armed <= armed | (fill[1] & ~s);
            update_strobe <= accept;
            pulse_error <= 1'b0;
            case (state)
                WAIT_RISE: if (rise) begin
                    state <= MEASURE;
                    width <= TIME_WIDTH'(1);
                end
                MEASURE: if (!s) begin
                    state <= WAIT_RISE;
                    pulse_error <= ~accept;
                end else begin
                    width <= width + 1'b1;
                    if (width == MAX_V) begin
                        state <= WAIT_FALL;
                        pulse_error <= 1'b1;
                    end
                end
                WAIT_FALL: if (!s) state <= WAIT_RISE;
                default: state <= WAIT_RISE;
            endcase
            if (accept) begin
                tcnt <= '0;
                value <= mapped;
                signal_lost <= 1'b0;
            end else begin
                tcnt <= tnext;
                if (tnext == TO) begin
                    signal_lost <= 1'b1;
                    value <= FAILSAFE_VALUE;
                end
            end
        end
    end
endmodule

// File: rtl/multi_channel_receiver.sv
// multi_channel_receiver: NUM_CHANNELS independent RC PWM decoders plus a
// registered all-channels-valid flag.
module multi_channel_receiver
    import multi_channel_receiver_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int TIME_WIDTH = PWM_TIME_BIT_WIDTH,
    parameter int VALUE_WIDTH = PWM_VALUE_BIT_WIDTH,
    parameter int MIN_PULSE_US = MIN_PULSE_US_DEF,
    parameter int MAX_PULSE_US = MAX_PULSE_US_DEF,
    parameter int MIN_VALID_US = MIN_VALID_US_DEF,
    parameter int MAX_VALID_US = MAX_VALID_US_DEF,
    parameter int VALUE_SHIFT = VALUE_SHIFT_DEF,
    parameter int TIMEOUT_US = TIMEOUT_US_DEF,
    parameter logic [NUM_CHANNELS*VALUE_WIDTH-1:0] FAILSAFE_VALUE = FAILSAFE_DEF
) (
    input  logic                                us_clk,
    input  logic                                reset,
    input  logic [NUM_CHANNELS-1:0]             pwm_in,
    output logic [NUM_CHANNELS*VALUE_WIDTH-1:0] value_out,
    output logic [NUM_CHANNELS-1:0]             update_strobe,
    output logic [NUM_CHANNELS-1:0]             signal_lost,
    output logic [NUM_CHANNELS-1:0]             pulse_error,
    output logic                                all_valid
);
    genvar i;
    generate
        for (i = 0; i < NUM_CHANNELS; i++) begin : g_ch
            rx_channel #(
                .TIME_WIDTH    (TIME_WIDTH),
                .VALUE_WIDTH   (VALUE_WIDTH),
                .MIN_PULSE_US  (MIN_PULSE_US),
                .MAX_PULSE_US  (MAX_PULSE_US),
                .MIN_VALID_US  (MIN_VALID_US),
                .MAX_VALID_US  (MAX_VALID_US),
                .VALUE_SHIFT   (VALUE_SHIFT),
                .TIMEOUT_US    (TIMEOUT_US),
                .FAILSAFE_VALUE(FAILSAFE_VALUE[i*VALUE_WIDTH +: VALUE_WIDTH])
            ) u_ch (
                .us_clk       (us_clk),
                .reset        (reset),
                .pwm          (pwm_in[i]),
                .value        (value_out[i*VALUE_WIDTH +: VALUE_WIDTH]),
                .update_strobe(update_strobe[i]),
                .signal_lost  (signal_lost[i]),
                .pulse_error  (pulse_error[i])
            );
        end
    endgenerate

    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) all_valid <= 1'b0;
        else all_valid <= ~|signal_lost;
    end
endmodule

// File: tb/tb_multi_channel_receiver.sv
// tb_multi_channel_receiver: table vectors, hand sequences for reset/timeout
// corners and randomized pulses checked against a width-to-value model.
module tb_multi_channel_receiver;
    logic us_clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] pwm_in = 4'b0;
    logic [31:0] value_out;
    logic [3:0] update_strobe, signal_lost, pulse_error;
    logic all_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cnt[4], err_cnt[4], strobe_cyc[4], err_cyc[4], lost_rise_cnt[4], lost_rise_cyc[4];
    int av_fall_cyc = -1;
    logic [3:0] lost_q = 4'hF;
    logic av_q = 1'b0;
    int rise_cyc[4], fall_cyc[4], pw[4], exp_val[4];

    typedef struct {
        int ch;
        int w;
        int val;
        int stb;
        int err;
    } vec_t;
    vec_t tbl[13];

    multi_channel_receiver dut (
        .us_clk       (us_clk),
        .reset        (reset),
        .pwm_in       (pwm_in),
        .value_out    (value_out),
        .update_strobe(update_strobe),
        .signal_lost  (signal_lost),
        .pulse_error  (pulse_error),
        .all_valid    (all_valid)
    );

    always #5 us_clk = ~us_clk;
    always @(posedge us_clk) cyc <= cyc + 1;

    always @(negedge us_clk) begin
        for (int c = 0; c < 4; c++) begin
            if (update_strobe[c]) begin
                strobe_cnt[c] <= strobe_cnt[c] + 1;
                strobe_cyc[c] <= cyc;
            end
            if (pulse_error[c]) begin
                err_cnt[c] <= err_cnt[c] + 1;
                err_cyc[c] <= cyc;
            end
            if (signal_lost[c] && !lost_q[c]) begin
                lost_rise_cnt[c] <= lost_rise_cnt[c] + 1;
                lost_rise_cyc[c] <= cyc;
            end
        end
        if (av_q && !all_valid) av_fall_cyc <= cyc;
        lost_q <= signal_lost;
        av_q <= all_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge us_clk);
    endtask

    function automatic int val(input int c);
        return int'(value_out[c*8 +: 8]);
    endfunction

    function automatic int map_w(input int w);
        int cl;
        int v;
        cl = w < 1000 ? 1000 : (w > 2000 ? 2000 : w);
        v = (cl - 1000) / 4;
        return v > 255 ? 255 : v;
    endfunction

    // drives every channel with pw[c] > 0 high for exactly pw[c] clock edges,
    // all starting on the same falling edge; caller must be at a negedge
    task automatic run_pulses();
        int mx;
        mx = 0;
        for (int c = 0; c < 4; c++) if (pw[c] > mx) mx = pw[c];
        for (int c = 0; c < 4; c++) begin
            if (pw[c] > 0) begin
                pwm_in[c] = 1'b1;
                rise_cyc[c] = cyc;
            end
        end
        for (int t = 1; t <= mx; t++) begin
            @(negedge us_clk);
            for (int c = 0; c < 4; c++) begin
                if (pw[c] == t) begin
                    pwm_in[c] = 1'b0;
                    fall_cyc[c] = cyc;
                end
            end
        end
        for (int c = 0; c < 4; c++) pw[c] = 0;
    endtask

    task automatic pulse(input int c, input int w);
        pw[c] = w;
        run_pulses();
    endtask

    initial begin
        int a, s0, e0, lr2, target, c, w;
        int rs[4], re[4], rw[4];
        bit acc;
        tbl[0]  = '{1, 900, 0, 1, 0};
        tbl[1]  = '{1, 2100, 250, 1, 0};
        tbl[2]  = '{1, 700, 250, 0, 1};
        tbl[3]  = '{1, 800, 0, 1, 0};
        tbl[4]  = '{1, 799, 0, 0, 1};
        tbl[5]  = '{1, 2200, 250, 1, 0};
        tbl[6]  = '{1, 2201, 250, 0, 1};
        tbl[7]  = '{3, 1000, 0, 1, 0};
        tbl[8]  = '{3, 1004, 1, 1, 0};
        tbl[9]  = '{3, 1003, 0, 1, 0};
        tbl[10] = '{3, 1999, 249, 1, 0};
        tbl[11] = '{3, 2000, 250, 1, 0};
        tbl[12] = '{3, 1500, 125, 1, 0};
        for (int i = 0; i < 4; i++) pw[i] = 0;

        wait_cycles(3);
        chk("reset_value_out", int'(value_out), 32'h7D7D7D00);
        chk("reset_signal_lost", int'(signal_lost), 15);
        chk("reset_update_strobe", int'(update_strobe), 0);
        chk("reset_pulse_error", int'(pulse_error), 0);
        chk("reset_all_valid", int'(all_valid), 0);
        reset = 1'b0;
        wait_cycles(4);

        // first pulse after reset on ch2
        s0 = strobe_cnt[2];
        pulse(2, 1500);
        wait_cycles(8);
        chk("ch2_1500_value", val(2), 125);
        chk("ch2_1500_strobe_count", strobe_cnt[2] - s0, 1);
        chk("ch2_1500_latency", strobe_cyc[2] - fall_cyc[2], 3);
        chk("ch2_1500_lost", int'(signal_lost[2]), 0);
        chk("ch2_1500_err_count", err_cnt[2], 0);

        // reset 500 us into a pulse, released while the pin is still high
        s0 = strobe_cnt[0];
        pwm_in[0] = 1'b1;
        wait_cycles(500);
        reset = 1'b1;
        wait_cycles(3);
        chk("midreset_value_out", int'(value_out), 32'h7D7D7D00);
        chk("midreset_signal_lost", int'(signal_lost), 15);
        reset = 1'b0;
        wait_cycles(1000);
        pwm_in[0] = 1'b0;
        wait_cycles(8);
        chk("midreset_partial_strobe", strobe_cnt[0] - s0, 0);
        chk("midreset_partial_lost", int'(signal_lost[0]), 1);
        pulse(0, 1500);
        wait_cycles(8);
        chk("midreset_next_value", val(0), 125);
        chk("midreset_next_strobe", strobe_cnt[0] - s0, 1);
        chk("midreset_next_lost", int'(signal_lost[0]), 0);

        // ch0 and ch2 accept together, then stay idle for the timeout window
        pw[0] = 1800;
        pw[2] = 1800;
        run_pulses();
        wait_cycles(8);
        a = strobe_cyc[0];
        chk("ch0_1800_latency", strobe_cyc[0] - fall_cyc[0], 3);
        chk("ch2_1800_latency", strobe_cyc[2] - fall_cyc[2], 3);
        chk("ch0_1800_value", val(0), 200);
        chk("ch2_1800_value", val(2), 200);
        lr2 = lost_rise_cnt[2];
        exp_val[1] = 125;
        exp_val[3] = 125;

        for (int i = 0; i < 13; i++) begin
            c = tbl[i].ch;
            s0 = strobe_cnt[c];
            e0 = err_cnt[c];
            pulse(c, tbl[i].w);
            wait_cycles(8);
            chk($sformatf("tbl%0d_ch%0d_w%0d_value", i, c, tbl[i].w), val(c), tbl[i].val);
            chk($sformatf("tbl%0d_strobe", i), strobe_cnt[c] - s0, tbl[i].stb);
            chk($sformatf("tbl%0d_err", i), err_cnt[c] - e0, tbl[i].err);
            if (tbl[i].stb == 1) chk($sformatf("tbl%0d_latency", i), strobe_cyc[c] - fall_cyc[c], 3);
            exp_val[c] = tbl[i].val;
        end
        chk("all_valid_after_accepts", int'(all_valid), 1);

        // ch3 stuck high: one error after 2201 us of high level, no update
        s0 = strobe_cnt[3];
        e0 = err_cnt[3];
        pulse(3, 5000);
        wait_cycles(8);
        chk("stuck_err_count", err_cnt[3] - e0, 1);
        chk("stuck_err_time", err_cyc[3] - rise_cyc[3], 2 + 2201);
        chk("stuck_strobe_count", strobe_cnt[3] - s0, 0);
        chk("stuck_value", val(3), exp_val[3]);
        pulse(3, 1200);
        wait_cycles(8);
        chk("after_stuck_value", val(3), 50);
        exp_val[3] = 50;

        // randomized simultaneous pulses on ch1 and ch3
        for (int r = 0; r < 6; r++) begin
            for (int k = 1; k < 4; k += 2) begin
                rw[k] = $urandom_range(600, 2400);
                pw[k] = rw[k];
                rs[k] = strobe_cnt[k];
                re[k] = err_cnt[k];
            end
            run_pulses();
            wait_cycles(8);
            for (int k = 1; k < 4; k += 2) begin
                acc = rw[k] >= 800 && rw[k] <= 2200;
                if (acc) exp_val[k] = map_w(rw[k]);
                chk($sformatf("rnd%0d_ch%0d_w%0d_value", r, k, rw[k]), val(k), exp_val[k]);
                chk($sformatf("rnd%0d_ch%0d_strobe", r, k), strobe_cnt[k] - rs[k], int'(acc));
                chk($sformatf("rnd%0d_ch%0d_err", r, k), err_cnt[k] - re[k], int'(!acc));
            end
        end

        // ch2 accepts exactly on the cycle its timeout would expire; ch0 times out
        target = a + 60000 - 3 - 1000;
        chk("timeout_window_not_passed", int'(cyc < target), 1);
        while (cyc < target) @(negedge us_clk);
        w = 1000;
        pulse(2, w);
        wait_cycles(8);
        chk("ch0_timeout_cycle", lost_rise_cyc[0] - a, 60000);
        chk("ch0_timeout_lost", int'(signal_lost[0]), 1);
        chk("ch0_timeout_value", val(0), 0);
        chk("all_valid_fall_cycle", av_fall_cyc - a, 60001);
        chk("all_valid_after_timeout", int'(all_valid), 0);
        chk("ch2_coincide_strobe_cycle", strobe_cyc[2] - a, 60000);
        chk("ch2_coincide_value", val(2), map_w(w));
        chk("ch2_coincide_lost", int'(signal_lost[2]), 0);
        chk("ch2_coincide_lost_rises", lost_rise_cnt[2] - lr2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
